// File: rtl/lvds_link_pkg.sv
// Shared LVDS link definitions: word tag layout, word builder and the
// training/idle bytes common to the framer and receiver.
package lvds_link_pkg;

  localparam int TAG_VALID_BIT = 31;
  localparam int ID_MSB        = 30;
  localparam int ID_LSB        = 29;
  localparam int PAY_W         = 29;

  localparam logic [7:0] TRAIN_0   = 8'h6A;
  localparam logic [7:0] TRAIN_1   = 8'hA5;
  localparam logic [7:0] TRAIN_2   = 8'h77;
  localparam logic [7:0] IDLE_BYTE = 8'h52;

  function automatic logic [31:0] make_word(input logic [1:0] id,
                                            input logic [PAY_W-1:0] payload);
    return {1'b1, id, payload};
  endfunction

endpackage

// File: rtl/lvds_tx_arbiter_if.sv
// Requester, framer and status signals of the LVDS transmit arbiter.
// slave is the arbiter side; master is the requester/framer side.
interface lvds_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
);
  import lvds_link_pkg::*;

  logic                     link_enable;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*PAY_W-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic [31:0]              enq_tx;
  logic                     RDY_enq_tx;
  logic                     EN_enq_tx;
  logic [1:0]               grant_id;
  logic [NUM_REQ*CNT_W-1:0] word_cnt;
  logic                     protocol_err;

  modport master (
    output link_enable, req_valid, req_data, EN_enq_tx,
    input  req_ready, enq_tx, RDY_enq_tx, grant_id, word_cnt, protocol_err
  );

  modport slave (
    input  link_enable, req_valid, req_data, EN_enq_tx,
    output req_ready, enq_tx, RDY_enq_tx, grant_id, word_cnt, protocol_err
  );

endinterface

// File: rtl/lvds_rr_pick.sv
// Combinational round-robin winner select: the owner keeps the grant while
// burst_ok, otherwise the first valid index after rr_ptr wins.
module lvds_rr_pick
  import lvds_link_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [1:0]         i_rr_ptr,
  input  logic [1:0]         i_owner,
  input  logic               i_burst_ok,
  output logic [NUM_REQ-1:0] o_pick,
  output logic [1:0]         o_id
);

  logic [1:0] w_idx [NUM_REQ];

  // w_idx[k] is the k-th candidate in scan order rr_ptr+1, rr_ptr+2, ...
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_scan
      assign w_idx[gi] = 2'((int'(i_rr_ptr) + gi + 1) % NUM_REQ);
    end
  endgenerate

  always_comb begin
    o_pick = '0;
    o_id   = '0;
    if (i_burst_ok && i_valid[i_owner]) begin
      o_pick[i_owner] = 1'b1;
      o_id            = i_owner;
    end else begin
      // Walk backwards so the earliest candidate in scan order is assigned last.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (i_valid[w_idx[k]]) begin
          o_pick            = '0;
          o_pick[w_idx[k]]  = 1'b1;
          o_id              = w_idx[k];
        end
      end
    end
  end

endmodule

// File: rtl/lvds_tx_arbiter.sv
// Round-robin arbiter sharing the 32-bit LVDS transmit word between requesters,
// with a one-word output slot, bounded bursts and per-channel word counters.
module lvds_tx_arbiter
  import lvds_link_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
) (
  input logic               tx_inclock,
  input logic               reset,
  lvds_tx_arbiter_if.slave  bus
);

  localparam logic [1:0] LAST_ID = 2'(NUM_REQ - 1);

  logic             r_slot_v;
  logic [31:0]      r_slot_word;
  logic [1:0]       r_grant_id;
  logic [1:0]       r_rr_ptr;
  logic [3:0]       r_burst_cnt;
  logic             r_protocol_err;
  logic [CNT_W-1:0] r_word_cnt [NUM_REQ];

  logic               w_slot_free;
  logic               w_burst_ok;
  logic               w_cont;
  logic               w_xfer;
  logic               w_drain;
  logic [NUM_REQ-1:0] w_pick;
  logic [1:0]         w_id;
  logic [1:0]         w_held_id;
  logic [PAY_W-1:0]   w_pay [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_chan
      assign w_pay[gi] = bus.req_data[gi*PAY_W +: PAY_W];
      assign bus.word_cnt[gi*CNT_W +: CNT_W] = r_word_cnt[gi];

      always_ff @(posedge tx_inclock) begin
        if (reset) begin
          r_word_cnt[gi] <= '0;
        end else if (w_drain && (w_held_id == 2'(gi))) begin
          r_word_cnt[gi] <= r_word_cnt[gi] + 1'b1;
        end
      end
    end
  endgenerate

  // burst_cnt == 0 means nobody owns the link yet, so the first win is by scan.
  assign w_slot_free = !r_slot_v || bus.EN_enq_tx;
  assign w_burst_ok  = (r_burst_cnt != 4'd0) && (r_burst_cnt < 4'(MAX_BURST));
  assign w_cont      = w_burst_ok && bus.req_valid[r_grant_id];
  assign w_held_id   = r_slot_word[ID_MSB:ID_LSB];
  assign w_drain     = bus.EN_enq_tx && r_slot_v;

  lvds_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_valid    (bus.req_valid),
    .i_rr_ptr   (r_rr_ptr),
    .i_owner    (r_grant_id),
    .i_burst_ok (w_burst_ok),
    .o_pick     (w_pick),
    .o_id       (w_id)
  );

  assign bus.req_ready    = (w_slot_free && bus.link_enable) ? w_pick : '0;
  assign w_xfer           = |bus.req_ready;
  assign bus.enq_tx       = r_slot_word;
  assign bus.RDY_enq_tx   = r_slot_v;
  assign bus.grant_id     = r_grant_id;
  assign bus.protocol_err = r_protocol_err;

  always_ff @(posedge tx_inclock) begin
    if (reset) begin
      r_slot_v       <= 1'b0;
      r_slot_word    <= '0;
      r_grant_id     <= LAST_ID;
      r_rr_ptr       <= LAST_ID;
      r_burst_cnt    <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_slot_word <= make_word(w_id, w_pay[w_id]);
        r_slot_v    <= 1'b1;
        r_grant_id  <= w_id;
        // An exhausted owner re-won by scan starts a fresh burst.
        if (w_cont) begin
          r_burst_cnt <= r_burst_cnt + 4'd1;
        end else begin
          r_burst_cnt <= 4'd1;
          r_rr_ptr    <= w_id;
        end
      end else if (bus.EN_enq_tx) begin
        r_slot_v <= 1'b0;
      end
      if (bus.EN_enq_tx && !r_slot_v) begin
        r_protocol_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lvds_tx_arbiter.sv
// Directed bench for lvds_tx_arbiter: a queue/arithmetic model is checked every
// cycle, and literal expectations pin the main scenarios.
module tb_lvds_tx_arbiter;
  import lvds_link_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 4;
  localparam int CNT_W     = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lvds_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus ();

  lvds_tx_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) dut (
    .tx_inclock (clk),
    .reset      (rst),
    .bus        (bus)
  );

  logic             tie_en = 1'b0;
  logic             en_man = 1'b0;
  logic [PAY_W-1:0] pay [NUM_REQ];

  assign bus.EN_enq_tx = tie_en ? bus.RDY_enq_tx : en_man;
  assign bus.req_data  = {pay[3], pay[2], pay[1], pay[0]};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_init = 0;
  bit          m_slot_v;
  logic [31:0] m_slot_word;
  logic [1:0]  m_grant;
  logic [1:0]  m_ptr;
  int          m_burst;
  bit          m_perr;
  logic [15:0] m_cnt [NUM_REQ];

  function automatic int model_winner();
    logic [3:0] v;
    v = bus.req_valid;
    if (!bus.link_enable || (m_slot_v && !bus.EN_enq_tx) || v == 4'b0) return -1;
    if (m_burst > 0 && m_burst < MAX_BURST && v[m_grant]) return int'(m_grant);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(m_ptr) + k) % NUM_REQ;
      if (v[2'(idx)]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_init      <= 1;
      m_slot_v    <= 0;
      m_slot_word <= '0;
      m_grant     <= 2'(NUM_REQ - 1);
      m_ptr       <= 2'(NUM_REQ - 1);
      m_burst     <= 0;
      m_perr      <= 0;
      for (int i = 0; i < NUM_REQ; i++) m_cnt[i] <= '0;
    end else if (m_init) begin
      if (bus.EN_enq_tx && m_slot_v) m_cnt[m_slot_word[30:29]] <= m_cnt[m_slot_word[30:29]] + 16'd1;
      if (bus.EN_enq_tx && !m_slot_v) m_perr <= 1;
      if (model_winner() >= 0) begin
        m_slot_word <= {1'b1, 2'(model_winner()), pay[2'(model_winner())]};
        m_slot_v    <= 1;
        m_grant     <= 2'(model_winner());
        if (model_winner() == int'(m_grant) && m_burst > 0 && m_burst < MAX_BURST) begin
          m_burst <= m_burst + 1;
        end else begin
          m_burst <= 1;
          m_ptr   <= 2'(model_winner());
        end
      end else if (bus.EN_enq_tx) begin
        m_slot_v <= 0;
      end
    end
  end

  // Compare process: every cycle once the model has seen reset.
  logic [3:0] exp_ready;
  always @(negedge clk) begin
    if (m_init) begin
      exp_ready = (model_winner() >= 0) ? (4'b0001 << model_winner()) : 4'b0000;
      check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      check("RDY_enq_tx", 64'(bus.RDY_enq_tx), 64'(m_slot_v));
      if (m_slot_v || !rst) check("enq_tx", 64'(bus.enq_tx), 64'(m_slot_word));
      check("grant_id", 64'(bus.grant_id), 64'(m_grant));
      check("word_cnt", 64'(bus.word_cnt), {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]});
      check("protocol_err", 64'(bus.protocol_err), 64'(m_perr));
    end
  end

  // Log of words taken by the framer: id and cycle number.
  int cyc = 0;
  int log_id [$];
  int log_cyc [$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && bus.EN_enq_tx && bus.RDY_enq_tx) begin
      log_id.push_back(int'(bus.enq_tx[30:29]));
      log_cyc.push_back(cyc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.link_enable = 1'b1;
    tie_en = 1'b0;
    en_man = 1'b0;
    cycles(2);
    rst = 1'b0;
    log_id.delete();
    log_cyc.delete();
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check({tag, "_rdy"},  64'(bus.RDY_enq_tx), 64'd0);
    check({tag, "_enq"},  64'(bus.enq_tx), 64'd0);
    check({tag, "_gid"},  64'(bus.grant_id), 64'd3);
    check({tag, "_cnt"},  64'(bus.word_cnt), 64'd0);
    check({tag, "_perr"}, 64'(bus.protocol_err), 64'd0);
    check({tag, "_rdyq"}, 64'(bus.req_ready), 64'd0);
  endtask

  int exp_ids [17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};

  initial begin
    bus.req_valid   = '0;
    bus.link_enable = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) pay[i] = '0;

    // 1: single word, EN tied to RDY
    do_reset();
    check_reset_state("t1_reset");
    cycles(1);
    bus.req_valid = 4'b0001;
    pay[0] = 29'h0ABCDEF;
    tie_en = 1'b1;
    cycles(1);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    check("t1_rdy", 64'(bus.RDY_enq_tx), 64'd1);
    check("t1_enq", 64'(bus.enq_tx), 64'h80ABCDEF);
    cycles(1);
    @(negedge clk);
    check("t1_cnt0", 64'(bus.word_cnt[15:0]), 64'd1);
    check("t1_rdy_off", 64'(bus.RDY_enq_tx), 64'd0);
    $display("t1 single word: %0d words logged", log_id.size());

    // 2: all four valid, round robin with bursts of 4, no bubbles
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) pay[i] = 29'(32'h100 + i);
    bus.req_valid = 4'b1111;
    tie_en = 1'b1;
    cycles(17);
    bus.req_valid = 4'b0000;
    cycles(3);
    check("t2_count", 64'(log_id.size()), 64'd17);
    if (log_id.size() == 17) begin
      for (int i = 0; i < 17; i++) begin
        check($sformatf("t2_id%0d", i), 64'(log_id[i]), 64'(exp_ids[i]));
        check($sformatf("t2_gap%0d", i), 64'(log_cyc[i] - log_cyc[0]), 64'(i));
      end
    end
    $display("t2 round robin: %0d words logged", log_id.size());

    // 3: only requester 2, ten words
    do_reset();
    pay[2] = 29'h1234567;
    bus.req_valid = 4'b0100;
    tie_en = 1'b1;
    cycles(10);
    bus.req_valid = 4'b0000;
    cycles(2);
    check("t3_count", 64'(log_id.size()), 64'd10);
    foreach (log_id[i]) check($sformatf("t3_id%0d", i), 64'(log_id[i]), 64'd2);
    @(negedge clk);
    check("t3_cnt2", 64'(bus.word_cnt[47:32]), 64'd10);
    $display("t3 lone requester: %0d words logged", log_id.size());

    // 4: slot full, framer stalls 5 cycles, then drain+refill same cycle
    do_reset();
    pay[0] = 29'h0000111;
    bus.req_valid = 4'b0001;
    cycles(1);
    pay[0] = 29'h0000222;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_stall_ready", 64'(bus.req_ready), 64'd0);
      check("t4_stall_enq", 64'(bus.enq_tx), 64'h80000111);
      check("t4_stall_cnt", 64'(bus.word_cnt), 64'd0);
      cycles(1);
    end
    en_man = 1'b1;
    @(negedge clk);
    check("t4_refill_ready", 64'(bus.req_ready), 64'd1);
    cycles(1);
    en_man = 1'b0;
    bus.req_valid = 4'b0000;
    @(negedge clk);
    check("t4_rdy", 64'(bus.RDY_enq_tx), 64'd1);
    check("t4_enq", 64'(bus.enq_tx), 64'h80000222);
    check("t4_cnt0", 64'(bus.word_cnt[15:0]), 64'd1);
    $display("t4 stall and refill: enq_tx=%h", bus.enq_tx);

    // 5: link drops while a word is held
    do_reset();
    pay[1] = 29'h0055AA0;
    bus.req_valid = 4'b0010;
    cycles(1);
    bus.link_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_hold_ready", 64'(bus.req_ready), 64'd0);
      check("t5_hold_enq", 64'(bus.enq_tx), 64'hA0055AA0);
      cycles(1);
    end
    en_man = 1'b1;
    @(negedge clk);
    check("t5_drain_ready", 64'(bus.req_ready), 64'd0);
    cycles(1);
    en_man = 1'b0;
    @(negedge clk);
    check("t5_rdy_off", 64'(bus.RDY_enq_tx), 64'd0);
    check("t5_cnt1", 64'(bus.word_cnt[31:16]), 64'd1);
    cycles(2);
    bus.link_enable = 1'b1;
    @(negedge clk);
    check("t5_relink_ready", 64'(bus.req_ready), 64'd2);
    cycles(1);
    bus.req_valid = 4'b0000;
    cycles(2);
    $display("t5 link drop: word_cnt=%h", bus.word_cnt);

    // 6: EN with nothing held
    do_reset();
    en_man = 1'b1;
    cycles(1);
    en_man = 1'b0;
    @(negedge clk);
    check("t6_perr", 64'(bus.protocol_err), 64'd1);
    check("t6_cnt", 64'(bus.word_cnt), 64'd0);
    check("t6_rdy", 64'(bus.RDY_enq_tx), 64'd0);
    cycles(3);
    @(negedge clk);
    check("t6_perr_sticky", 64'(bus.protocol_err), 64'd1);
    $display("t6 protocol error: protocol_err=%0d", bus.protocol_err);

    // 6b: reset mid-burst clears everything, including the sticky error
    bus.req_valid = 4'b1111;
    tie_en = 1'b1;
    cycles(6);
    @(negedge clk);
    check("t6b_pre_rdy", 64'(bus.RDY_enq_tx), 64'd1);
    check("t6b_pre_perr", 64'(bus.protocol_err), 64'd1);
    cycles(1);
    rst = 1'b1;
    bus.req_valid = 4'b0000;
    tie_en = 1'b0;
    cycles(1);
    rst = 1'b0;
    check_reset_state("t6b_reset");
    $display("t6b reset mid-burst: grant_id=%0d", bus.grant_id);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, limit 100000 required");
    $fatal(1);
  end

endmodule
